// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command codes and the power-up command ROM for lcd_controller.
// The WRAP_LOAD state exists only when LCD_AUTOWRAP_EN is defined.
package lcd_pkg;

`ifdef LCD_AUTOWRAP_EN
  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, STROBE, EXEC_WAIT, IDLE, WRAP_LOAD
  } lcd_state_t;
`else
  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, STROBE, EXEC_WAIT, IDLE
  } lcd_state_t;
`endif

  localparam logic [7:0] LCD_CMD_FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON         = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR           = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME            = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] LCD_CMD_LINE0           = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1           = 8'hC0;

  localparam logic [7:0] LCD_INIT_ROM [0:3] = '{
    LCD_CMD_FUNC_8BIT_2LINE, LCD_CMD_DISP_ON, LCD_CMD_CLEAR, LCD_CMD_ENTRY_INC
  };

  // Clear and home need the long execution time on the panel.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Single down-counter delay timer: start loads a cycle count, done pulses on the last cycle.
// A load value of 0 behaves as 1 cycle; RST_VAL lets the first delay run straight out of reset.
module lcd_delay_timer #(
  parameter int unsigned W = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = (load_i == '0) ? W'(1) : load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= (RST_VAL == '0) ? W'(1) : RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_controller.sv
// Write-only HD44780 sequencer: power-up wait, fixed init ROM, then host bytes over valid/ready.
// Define LCD_AUTOWRAP_EN to track the cursor and auto-issue line-change commands after column 15.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned POWERON_WAIT_CYCLES = 750000,
  parameter int unsigned SETUP_CYCLES        = 2,
  parameter int unsigned ENABLE_CYCLES       = 25,
  parameter int unsigned CMD_WAIT_CYCLES     = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES   = 82000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int unsigned MAX_A = (POWERON_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ?
                                  POWERON_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAX_B = (CMD_WAIT_CYCLES > ENABLE_CYCLES) ?
                                  CMD_WAIT_CYCLES : ENABLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_P = (MAX_C > SETUP_CYCLES) ? MAX_C : SETUP_CYCLES;
  localparam int unsigned TMR_W = $clog2(MAX_P + 1);

  lcd_state_t       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             tmr_start;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_done;
`ifdef LCD_AUTOWRAP_EN
  logic [3:0]       col_q, col_d;
  logic             line_q, line_d;
  logic             wrap_q, wrap_d;
`endif

  lcd_delay_timer #(
    .W       (TMR_W),
    .RST_VAL (TMR_W'(POWERON_WAIT_CYCLES))
  ) u_timer (
    .clk     (CLOCK_50),
    .rst     (reset),
    .start_i (tmr_start),
    .load_i  (tmr_load),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    en_d        = en_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    tmr_start   = 1'b0;
    tmr_load    = TMR_W'(SETUP_CYCLES);
`ifdef LCD_AUTOWRAP_EN
    col_d       = col_q;
    line_d      = line_q;
    wrap_d      = wrap_q;
`endif
    case (state_q)
      PWR_WAIT: begin
        if (tmr_done) begin
          state_d = INIT_LOAD;
          idx_d   = 2'd0;
        end
      end
      INIT_LOAD: begin
        data_d    = LCD_INIT_ROM[idx_q];
        rs_d      = 1'b0;
        tmr_start = 1'b1;
        state_d   = SETUP;
      end
      SETUP: begin
        if (tmr_done) begin
          en_d      = 1'b1;
          tmr_start = 1'b1;
          tmr_load  = TMR_W'(ENABLE_CYCLES);
          state_d   = STROBE;
        end
      end
      STROBE: begin
        if (tmr_done) begin
          en_d      = 1'b0;
          tmr_start = 1'b1;
          tmr_load  = lcd_is_long_cmd(rs_q, data_q) ? TMR_W'(CLEAR_WAIT_CYCLES)
                                                    : TMR_W'(CMD_WAIT_CYCLES);
          state_d   = EXEC_WAIT;
        end
      end
      EXEC_WAIT: begin
        if (tmr_done) begin
          if (!init_done_q) begin
            if (idx_q == 2'd3) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = INIT_LOAD;
            end
`ifdef LCD_AUTOWRAP_EN
          end else if (wrap_q) begin
            state_d = WRAP_LOAD;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (wr_valid && init_done_q) begin
          data_d    = wr_data;
          rs_d      = wr_rs;
          tmr_start = 1'b1;
          state_d   = SETUP;
`ifdef LCD_AUTOWRAP_EN
          // The wrap is decided on the column the character lands in.
          if (wr_rs) begin
            wrap_d = (col_q == 4'hF);
            col_d  = col_q + 4'd1;
          end else if (lcd_is_long_cmd(wr_rs, wr_data)) begin
            col_d  = 4'd0;
            line_d = 1'b0;
          end else if (wr_data[7]) begin
            col_d  = wr_data[3:0];
            line_d = wr_data[6];
          end
`endif
        end
      end
`ifdef LCD_AUTOWRAP_EN
      WRAP_LOAD: begin
        data_d    = line_q ? LCD_CMD_LINE0 : LCD_CMD_LINE1;
        rs_d      = 1'b0;
        line_d    = ~line_q;
        col_d     = 4'd0;
        wrap_d    = 1'b0;
        tmr_start = 1'b1;
        state_d   = SETUP;
      end
`endif
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
      col_q       <= 4'd0;
      line_q      <= 1'b0;
      wrap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
`ifdef LCD_AUTOWRAP_EN
      col_q       <= col_d;
      line_q      <= line_d;
      wrap_q      <= wrap_d;
`endif
    end
  end

  assign wr_ready  = (state_q == IDLE) && init_done_q;
  assign init_done = init_done_q;
  assign LCD_DATA  = data_q;
  assign LCD_RS    = rs_q;
  assign LCD_EN    = en_q;
  assign LCD_RW    = 1'b0;
  assign LCD_ON    = 1'b1;
  assign LCD_BLON  = 1'b1;

endmodule
